// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    ERROR    = 4'd10
  } state_t;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  // ALU_2to1 operation codes
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_XOR = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_SLL = 3'b100;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_XOR = 3'b100;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;

  // State entered after DECODE for a given opcode; unknown opcodes trap.
  function automatic state_t decode_target(input logic [OP_W-1:0] op);
    state_t target;
    case (op)
      OP_LW, OP_SW: target = MEMADR;
      OP_RTYPE:     target = EXECUTER;
      OP_ITYPE:     target = EXECUTEI;
      OP_BEQ:       target = BEQ;
      default:      target = ERROR;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps ALUOp/Funct3/Funct7b5 to an ALU_2to1 code and
// flags funct combinations the datapath does not implement.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic                Op5,
  input  logic [F3_W-1:0]     Funct3,
  input  logic                Funct7b5,
  input  logic [ALUOP_W-1:0]  ALUOp,
  output logic [ALUC_W-1:0]   ALUControl,
  output logic                FunctIllegal
);

  // Funct7b5 only selects an alternate op for R-type; for I-type it is immediate data.
  logic r_alt;
  assign r_alt = Op5 & Funct7b5;

  always_comb begin
    ALUControl   = ALU_ADD;
    FunctIllegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct3)
          F3_ADD: ALUControl = r_alt ? ALU_SUB : ALU_ADD;
          F3_SLL: begin
            if (Funct7b5) FunctIllegal = 1'b1;
            else          ALUControl   = ALU_SLL;
          end
          F3_XOR: begin
            if (r_alt) FunctIllegal = 1'b1;
            else       ALUControl   = ALU_XOR;
          end
          F3_AND: begin
            if (r_alt) FunctIllegal = 1'b1;
            else       ALUControl   = ALU_AND;
          end
          default: FunctIllegal = 1'b1;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// traps into a sticky ERROR state on unsupported instructions.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic [F3_W-1:0]    Funct3,
  input  logic               Funct7b5,
  input  logic               Zero,
  output logic [ALUC_W-1:0]  ALUControl,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [SEL_W-1:0]   ResultSrc,
  output logic [SEL_W-1:0]   ImmSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               Illegal
);

  state_t state;
  state_t state_next;

  logic [ALUOP_W-1:0] alu_op;
  logic [ALUC_W-1:0]  dec_alu_control;
  logic               funct_illegal;

  logic [SEL_W-1:0] alu_src_a;
  logic [SEL_W-1:0] alu_src_b;
  logic [SEL_W-1:0] result_src;
  logic [SEL_W-1:0] imm_src;
  logic             adr_src;
  logic             ir_write;
  logic             reg_write;
  logic             mem_write;
  logic             pc_write;
  logic             illegal;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // ALU operation class per state, kept apart from the main decode to avoid a feedback path
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state)
      EXECUTER, EXECUTEI: alu_op = ALUOP_FUNCT;
      BEQ:                alu_op = ALUOP_SUB;
      default:            alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .Op5          (Op[5]),
    .Funct3       (Funct3),
    .Funct7b5     (Funct7b5),
    .ALUOp        (alu_op),
    .ALUControl   (dec_alu_control),
    .FunctIllegal (funct_illegal)
  );

  // Next-state and per-state datapath controls
  always_comb begin
    state_next = state;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    illegal    = 1'b0;

    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_B;
        state_next = decode_target(Op);
      end
      MEMADR: begin
        // Op[5] separates sw from lw
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        imm_src    = Op[5] ? IMM_S : IMM_I;
        state_next = Op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        state_next = funct_illegal ? ERROR : ALUWB;
      end
      EXECUTEI: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        state_next = funct_illegal ? ERROR : ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        pc_write   = Zero;
        state_next = FETCH;
      end
      ERROR: begin
        illegal    = 1'b1;
        state_next = ERROR;
      end
      default: begin
        illegal    = 1'b1;
        state_next = ERROR;
      end
    endcase
  end

  assign ALUControl = dec_alu_control;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ImmSrc     = imm_src;
  assign AdrSrc     = adr_src;
  assign Illegal    = illegal;

  // Reset blocks every architectural write in the cycle it is asserted
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign PCWrite  = pc_write  & ~reset;

endmodule
